// File: rtl/load_store_unit_if.sv
// Request/response and DataMemory byte-bus bundle for load_store_unit.
// slave = the unit itself; master = the CPU-side requester together with the memory it talks to.
interface load_store_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_word;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              resp_valid;
  logic [15:0]       resp_rdata;
  logic              resp_error;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req_valid, req_write, req_word, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error, busy,
           mem_address, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_word, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, busy,
           mem_address, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/word load-store sequencer onto an 8-bit DataMemory bus, one byte per ACCESS cycle.
// Optional macro LSU_MISALIGN_TRAP_EN: odd-address word requests return resp_error without touching memory.
module load_store_unit #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int ADDR_W           = 8
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam bit         HAS_WAIT  = (MEM_READ_LATENCY > 0);
  localparam logic [1:0] WAIT_INIT = 2'(HAS_WAIT ? MEM_READ_LATENCY - 1 : 0);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              word_q, word_d;
  logic              byte_idx_q, byte_idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              sample;
  logic              advance;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              resp_error_q, resp_error_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    sample     = 1'b0;
    advance    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    resp_error_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          write_d    = bus.req_write;
          word_d     = bus.req_word;
          byte_idx_d = 1'b0;
          state_d    = ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
          if (bus.req_word && bus.req_addr[0]) begin
            state_d      = RESP;
            resp_error_d = 1'b1;
          end
`endif
        end
      end
      ACCESS: begin
        if (write_q) begin
          advance = 1'b1;
        end else if (HAS_WAIT) begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          sample  = 1'b1;
          advance = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          sample  = 1'b1;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The visible result only changes on the edge that enters RESP, so it holds between responses.
    if (sample) begin
      if (!word_q) begin
        rdata_d = {8'h00, bus.mem_rdata};
      end else if (!byte_idx_q) begin
        lo_d = bus.mem_rdata;
      end else begin
        rdata_d = {bus.mem_rdata, lo_q};
      end
    end

    if (advance) begin
      if (word_q && !byte_idx_q) begin
        byte_idx_d = 1'b1;
        state_d    = ACCESS;
      end else begin
        state_d = RESP;
      end
    end

    // Outputs are decoded from the next state so they are registered and aligned with it.
    req_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    resp_valid_d  = (state_d == RESP);
    mem_read_d    = (state_d == ACCESS) && !write_d;
    mem_write_d   = (state_d == ACCESS) && write_d;
    mem_address_d = addr_d + ADDR_W'(byte_idx_d);
    mem_wdata_d   = byte_idx_d ? wdata_d[15:8] : wdata_d[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      word_q        <= 1'b0;
      byte_idx_q    <= 1'b0;
      cnt_q         <= '0;
      lo_q          <= '0;
      rdata_q       <= '0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_error_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      word_q        <= word_d;
      byte_idx_q    <= byte_idx_d;
      cnt_q         <= cnt_d;
      lo_q          <= lo_d;
      rdata_q       <= rdata_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      resp_valid_q  <= resp_valid_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_error_q  <= resp_error_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_wdata   = mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.resp_error  = resp_error_q;
`else
  assign bus.resp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: unit A with read latency 1, unit B with read latency 0.
// Stimulus pushes expected memory cycles and responses; a negedge monitor pops and compares.
module tb_load_store_unit;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic chk_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if #(.ADDR_W(AW)) ifa ();
  load_store_unit_if #(.ADDR_W(AW)) ifb ();

  load_store_unit #(.MEM_READ_LATENCY(1), .ADDR_W(AW)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  load_store_unit #(.MEM_READ_LATENCY(0), .ADDR_W(AW)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Memory models: A has a one-stage read pipeline, B answers combinationally.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] pipe_a = 8'h00;

  always @(posedge clk) begin
    if (!reset) begin
      mem_a[8'h20] <= 8'h34;
      mem_a[8'h21] <= 8'h12;
      mem_b[8'h05] <= 8'h5A;
      mem_b[8'h06] <= 8'hC3;
    end else begin
      if (ifa.mem_write) mem_a[ifa.mem_address] <= ifa.mem_wdata;
      if (ifa.mem_read)  pipe_a <= mem_a[ifa.mem_address];
      if (ifb.mem_write) mem_b[ifb.mem_address] <= ifb.mem_wdata;
    end
  end

  assign ifa.mem_rdata = pipe_a;
  assign ifb.mem_rdata = ifb.mem_read ? mem_b[ifb.mem_address] : 8'h00;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } mem_t;

  resp_t rq_a[$];
  resp_t rq_b[$];
  mem_t  mq_a[$];
  mem_t  mq_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_mem(input int inst, input logic wr, input logic [7:0] addr, input logic [7:0] data);
    mem_t m;
    m.wr = wr; m.addr = addr; m.data = data;
    if (inst == 0) mq_a.push_back(m); else mq_b.push_back(m);
  endtask

  task automatic exp_resp(input int inst, input int acc, input int lat, input logic [15:0] rdata, input logic err);
    resp_t r;
    r.cyc = acc + lat - 1; r.rdata = rdata; r.err = err;
    if (inst == 0) rq_a.push_back(r); else rq_b.push_back(r);
  endtask

  task automatic mon(input int inst, input logic rv, input logic [15:0] rd, input logic re,
                     input logic mr, input logic mw, input logic [7:0] ma, input logic [7:0] md);
    mem_t  m;
    resp_t r;
    int    qs;
    string tag;
    tag = (inst == 0) ? "A" : "B";
    if (mr && mw) begin
      tests++; fails++;
      $display("FAIL %s rw_exclusive: mem_read and mem_write both 1 (cyc %0d)", tag, cyc);
    end
    if (mr || mw) begin
      qs = (inst == 0) ? mq_a.size() : mq_b.size();
      if (qs == 0) begin
        check({tag, " unexpected_mem"}, {23'b0, mw, ma}, 32'hFFFF_FFFF);
      end else begin
        m = (inst == 0) ? mq_a.pop_front() : mq_b.pop_front();
        check({tag, " mem_write"}, mw, m.wr);
        check({tag, " mem_address"}, ma, m.addr);
        if (m.wr) check({tag, " mem_wdata"}, md, m.data);
      end
    end
    if (rv) begin
      qs = (inst == 0) ? rq_a.size() : rq_b.size();
      if (qs == 0) begin
        check({tag, " unexpected_resp"}, {15'b0, re, rd}, 32'hFFFF_FFFF);
      end else begin
        r = (inst == 0) ? rq_a.pop_front() : rq_b.pop_front();
        $display("[TB] %s resp cyc=%0d rdata=%h err=%b", tag, cyc, rd, re);
        check({tag, " resp_cycle"}, cyc, r.cyc);
        check({tag, " resp_rdata"}, rd, r.rdata);
        check({tag, " resp_error"}, re, r.err);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.resp_valid, ifa.resp_rdata, ifa.resp_error, ifa.mem_read, ifa.mem_write, ifa.mem_address, ifa.mem_wdata);
    mon(1, ifb.resp_valid, ifb.resp_rdata, ifb.resp_error, ifb.mem_read, ifb.mem_write, ifb.mem_address, ifb.mem_wdata);
    if (chk_busy) check("B busy_vs_ready", ifb.busy, !ifb.req_ready);
  end

  task automatic drive(input int inst, input logic v, input logic w, input logic wd,
                       input logic [7:0] a, input logic [15:0] d);
    if (inst == 0) begin
      ifa.req_valid = v; ifa.req_write = w; ifa.req_word = wd; ifa.req_addr = a; ifa.req_wdata = d;
    end else begin
      ifb.req_valid = v; ifb.req_write = w; ifb.req_word = wd; ifb.req_addr = a; ifb.req_wdata = d;
    end
  endtask

  // Presents a request and returns the cycle number established by its accept edge; valid stays high.
  task automatic issue(input int inst, input logic w, input logic wd, input logic [7:0] a,
                       input logic [15:0] d, output int acc);
    int n;
    @(negedge clk);
    drive(inst, 1'b1, w, wd, a, d);
    n = 0;
    while (((inst == 0) ? ifa.req_ready : ifb.req_ready) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout: inst %0d addr %h not accepted in 50 cycles", inst, a);
      acc = -1000;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
  endtask

  task automatic chk_zero(input int inst, input string name);
    if (inst == 0)
      check(name, {ifa.req_ready, ifa.busy, ifa.resp_valid, ifa.resp_error, ifa.mem_read, ifa.mem_write,
                   ifa.resp_rdata, ifa.mem_address | ifa.mem_wdata}, 32'h0);
    else
      check(name, {ifb.req_ready, ifb.busy, ifb.resp_valid, ifb.resp_error, ifb.mem_read, ifb.mem_write,
                   ifb.resp_rdata, ifb.mem_address | ifb.mem_wdata}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int a1;
    int a2;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
    chk_zero(0, "A reset_outputs");
    chk_zero(1, "B reset_outputs");
    reset = 1'b1;
    #1 check("A ready_before_edge", ifa.req_ready, 1'b0);
    @(posedge clk); #1;
    check("A ready_after_release", ifa.req_ready, 1'b1);
    check("B ready_after_release", ifb.req_ready, 1'b1);

    // Word load abandoned by reset during its first WAIT cycle.
    exp_mem(0, 1'b0, 8'h20, 8'h00);
    issue(0, 1'b0, 1'b1, 8'h20, 16'h0000, acc);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1 chk_zero(0, "A midop_reset_outputs");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 check("A ready_before_edge2", ifa.req_ready, 1'b0);
    @(posedge clk); #1;
    check("A ready_after_release2", ifa.req_ready, 1'b1);
    check("A leftover_mem_after_reset", mq_a.size(), 0);

    exp_mem(0, 1'b1, 8'h10, 8'hA5);
    issue(0, 1'b1, 1'b0, 8'h10, 16'h00A5, acc);
    exp_resp(0, acc, 2, 16'h0000, 1'b0);

    exp_mem(0, 1'b1, 8'h11, 8'hC3);
    issue(0, 1'b1, 1'b0, 8'h11, 16'h77C3, acc);
    exp_resp(0, acc, 2, 16'h0000, 1'b0);

    exp_mem(0, 1'b0, 8'h10, 8'h00);
    issue(0, 1'b0, 1'b0, 8'h10, 16'h0000, acc);
    exp_resp(0, acc, 3, 16'h00A5, 1'b0);

    exp_mem(0, 1'b0, 8'h20, 8'h00);
    exp_mem(0, 1'b0, 8'h21, 8'h00);
    issue(0, 1'b0, 1'b1, 8'h20, 16'h0000, acc);
    exp_resp(0, acc, 5, 16'h1234, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 1'b1, 1'b1, 8'hFF, 16'hBEEF, acc);
    exp_resp(0, acc, 1, 16'h1234, 1'b1);
    issue(0, 1'b0, 1'b1, 8'hFF, 16'h0000, acc);
    exp_resp(0, acc, 1, 16'h1234, 1'b1);
`else
    exp_mem(0, 1'b1, 8'hFF, 8'hEF);
    exp_mem(0, 1'b1, 8'h00, 8'hBE);
    issue(0, 1'b1, 1'b1, 8'hFF, 16'hBEEF, acc);
    exp_resp(0, acc, 3, 16'h1234, 1'b0);
    exp_mem(0, 1'b0, 8'hFF, 8'h00);
    exp_mem(0, 1'b0, 8'h00, 8'h00);
    issue(0, 1'b0, 1'b1, 8'hFF, 16'h0000, acc);
    exp_resp(0, acc, 5, 16'hBEEF, 1'b0);
`endif

    exp_mem(0, 1'b0, 8'h11, 8'h00);
    issue(0, 1'b0, 1'b0, 8'h11, 16'h0000, acc);
    exp_resp(0, acc, 3, 16'h00C3, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Back-to-back byte loads on the zero-latency unit with req_valid held high.
    chk_busy = 1'b1;
    exp_mem(1, 1'b0, 8'h05, 8'h00);
    exp_mem(1, 1'b0, 8'h06, 8'h00);
    issue(1, 1'b0, 1'b0, 8'h05, 16'h0000, a1);
    exp_resp(1, a1, 2, 16'h005A, 1'b0);
    issue(1, 1'b0, 1'b0, 8'h06, 16'h0000, a2);
    exp_resp(1, a2, 2, 16'h00C3, 1'b0);
    check("B back_to_back_accept", a2, a1 + 3);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

    repeat (12) @(negedge clk);
    chk_busy = 1'b0;
    check("A pending_resp", rq_a.size(), 0);
    check("B pending_resp", rq_b.size(), 0);
    check("A pending_mem", mq_a.size(), 0);
    check("B pending_mem", mq_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
